// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: fetch/IF-ID/ID-EX sequencing controller.
// Starts/halts fetch, inserts load-use bubbles, and holds a PC redirect
// until fetch acknowledges it, then flushes the wrong-path instructions.
module pipeline_ctrl #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 c_clk,
  input  logic                 c_rst,
  input  logic                 c_i_start,
  input  logic                 c_i_halt,
  input  logic                 c_i_hazard,
  input  logic                 c_i_branch,
  input  logic [PC_WIDTH-1:0]  c_i_target,
  input  logic                 c_i_fetch_ce,
  output logic                 c_o_fetch_ce,
  output logic                 c_o_change_pc,
  output logic [PC_WIDTH-1:0]  c_o_pc,
  output logic                 c_o_stall_ifid,
  output logic                 c_o_flush_ifid,
  output logic                 c_o_flush_idex,
  output logic                 c_o_busy,
  output logic [CNT_WIDTH-1:0] c_o_redirects
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STALL    = 3'd2,
    REDIRECT = 3'd3,
    FLUSH    = 3'd4,
    HALT     = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [FCW-1:0] flush_cnt, flush_cnt_nxt;
  logic           accept;

  logic fetch_ce_d, change_pc_d, stall_ifid_d, flush_ifid_d, flush_idex_d, busy_d;

  // State and flush-counter register
  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state logic; branch always wins where it is honoured
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        if (c_i_start) state_nxt = RUN;
      end
      RUN: begin
        if (c_i_branch) begin
          state_nxt = REDIRECT;
          accept    = 1'b1;
        end else if (c_i_hazard) begin
          state_nxt = STALL;
        end else if (c_i_halt) begin
          state_nxt = HALT;
        end
      end
      STALL: begin
        if (c_i_branch) begin
          state_nxt = REDIRECT;
          accept    = 1'b1;
        end else if (!c_i_hazard) begin
          state_nxt = RUN;
        end
      end
      REDIRECT: begin
        if (c_i_branch) begin
          accept = 1'b1;
        end else if (c_i_fetch_ce) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (c_i_branch) begin
          state_nxt = REDIRECT;
          accept    = 1'b1;
        end else if (flush_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - FCW'(1);
        end
      end
      HALT: begin
        if (c_i_start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so outputs are ready one cycle after the request edge
  always_comb begin
    fetch_ce_d   = 1'b0;
    change_pc_d  = 1'b0;
    stall_ifid_d = 1'b0;
    flush_ifid_d = 1'b0;
    flush_idex_d = 1'b0;
    busy_d       = 1'b0;
    unique case (state_nxt)
      RUN: begin
        fetch_ce_d = 1'b1;
        busy_d     = 1'b1;
      end
      STALL: begin
        stall_ifid_d = 1'b1;
        flush_idex_d = 1'b1;
        busy_d       = 1'b1;
      end
      REDIRECT: begin
        fetch_ce_d   = 1'b1;
        change_pc_d  = 1'b1;
        flush_ifid_d = 1'b1;
        flush_idex_d = 1'b1;
        busy_d       = 1'b1;
      end
      FLUSH: begin
        fetch_ce_d   = 1'b1;
        flush_ifid_d = 1'b1;
        busy_d       = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      c_o_fetch_ce   <= 1'b0;
      c_o_change_pc  <= 1'b0;
      c_o_stall_ifid <= 1'b0;
      c_o_flush_ifid <= 1'b0;
      c_o_flush_idex <= 1'b0;
      c_o_busy       <= 1'b0;
    end else begin
      c_o_fetch_ce   <= fetch_ce_d;
      c_o_change_pc  <= change_pc_d;
      c_o_stall_ifid <= stall_ifid_d;
      c_o_flush_ifid <= flush_ifid_d;
      c_o_flush_idex <= flush_idex_d;
      c_o_busy       <= busy_d;
    end
  end

  // Redirect target latch and saturating redirect counter, both on accepted branches only
  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      c_o_pc        <= '0;
      c_o_redirects <= '0;
    end else if (accept) begin
      c_o_pc <= c_i_target;
      if (c_o_redirects != '1) c_o_redirects <= c_o_redirects + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector table plus randomized run against a flag-based model.
module tb_pipeline_ctrl;

  localparam int unsigned PW = 32;
  localparam int unsigned FC = 2;

  logic          clk, rst_n;
  logic          start, halt, hazard, branch, ack;
  logic [PW-1:0] target;
  logic          fce, cpc, stl, fif, fid, bsy;
  logic [PW-1:0] pc;
  logic [7:0]    cnt;
  logic          fce2, cpc2, stl2, fif2, fid2, bsy2;
  logic [PW-1:0] pc2;
  logic [1:0]    cnt2;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.PC_WIDTH(PW), .FLUSH_CYCLES(FC), .CNT_WIDTH(8)) dut (
    .c_clk(clk), .c_rst(rst_n), .c_i_start(start), .c_i_halt(halt),
    .c_i_hazard(hazard), .c_i_branch(branch), .c_i_target(target),
    .c_i_fetch_ce(ack), .c_o_fetch_ce(fce), .c_o_change_pc(cpc), .c_o_pc(pc),
    .c_o_stall_ifid(stl), .c_o_flush_ifid(fif), .c_o_flush_idex(fid),
    .c_o_busy(bsy), .c_o_redirects(cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation
  pipeline_ctrl #(.PC_WIDTH(PW), .FLUSH_CYCLES(FC), .CNT_WIDTH(2)) dut2 (
    .c_clk(clk), .c_rst(rst_n), .c_i_start(start), .c_i_halt(halt),
    .c_i_hazard(hazard), .c_i_branch(branch), .c_i_target(target),
    .c_i_fetch_ce(ack), .c_o_fetch_ce(fce2), .c_o_change_pc(cpc2), .c_o_pc(pc2),
    .c_o_stall_ifid(stl2), .c_o_flush_ifid(fif2), .c_o_flush_idex(fid2),
    .c_o_busy(bsy2), .c_o_redirects(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          st, ha, hz, br;
    logic [PW-1:0] tgt;
    logic          ak;
    logic          e_fce, e_cpc;
    logic [PW-1:0] e_pc;
    logic          e_stl, e_fif, e_fid, e_bsy;
    int            e_cnt;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  // Reference model: activity/stall/pending flags and remaining flush cycles
  bit          m_active, m_stalled, m_pending;
  int          m_flush_left;
  logic [PW-1:0] m_pc;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic e_fce, input logic e_cpc,
                           input logic [PW-1:0] e_pc, input logic e_stl, input logic e_fif,
                           input logic e_fid, input logic e_bsy, input int e_cnt);
    int sat;
    sat = (e_cnt > 3) ? 3 : e_cnt;
    check({name, ".ctl"}, 64'({fce, cpc, stl, fif, fid, bsy}),
          64'({e_fce, e_cpc, e_stl, e_fif, e_fid, e_bsy}));
    check({name, ".pc"}, 64'(pc), 64'(e_pc));
    check({name, ".cnt"}, 64'(cnt), 64'(e_cnt > 255 ? 255 : e_cnt));
    check({name, ".cnt2"}, 64'(cnt2), 64'(sat));
  endtask

  task automatic model_reset();
    m_active = 0; m_stalled = 0; m_pending = 0; m_flush_left = 0;
    m_pc = '0; m_cnt = 0;
  endtask

  task automatic take_branch();
    m_pending    = 1;
    m_stalled    = 0;
    m_flush_left = 0;
    m_pc         = target;
    m_cnt++;
  endtask

  // One clock edge of the model using the currently driven inputs
  task automatic model_step();
    if (!m_active) begin
      if (start) m_active = 1;
    end else if (m_pending) begin
      if (branch) take_branch();
      else if (ack) begin
        m_pending    = 0;
        m_flush_left = FC;
      end
    end else if (m_flush_left > 0) begin
      if (branch) take_branch();
      else m_flush_left--;
    end else if (branch) begin
      take_branch();
    end else if (m_stalled) begin
      m_stalled = hazard;
    end else if (hazard) begin
      m_stalled = 1;
    end else if (halt) begin
      m_active = 0;
    end
  endtask

  task automatic check_model(input string name);
    bit in_flush;
    in_flush = (m_flush_left > 0);
    check_all(name,
              m_active && !m_stalled,
              m_active && m_pending,
              m_pc,
              m_active && m_stalled,
              m_active && (m_pending || in_flush),
              m_active && (m_pending || m_stalled),
              m_active,
              m_cnt);
  endtask

  task automatic drive(input logic s, input logic h, input logic z, input logic b,
                       input logic [PW-1:0] t, input logic a);
    start = s; halt = h; hazard = z; branch = b; target = t; ack = a;
  endtask

  initial begin
    //        st ha hz br tgt        ak  fce cpc pc         stl fif fid bsy cnt
    vecs[0]  = '{0, 0, 0, 0, 32'h0,   0,  0,  0, 32'h0,     0,  0,  0,  0,  0};
    vecs[1]  = '{1, 0, 0, 0, 32'h0,   0,  1,  0, 32'h0,     0,  0,  0,  1,  0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,   0,  1,  0, 32'h0,     0,  0,  0,  1,  0};
    vecs[3]  = '{0, 0, 1, 0, 32'h0,   0,  0,  0, 32'h0,     1,  0,  1,  1,  0};
    vecs[4]  = '{0, 0, 1, 0, 32'h0,   0,  0,  0, 32'h0,     1,  0,  1,  1,  0};
    vecs[5]  = '{0, 0, 1, 0, 32'h0,   0,  0,  0, 32'h0,     1,  0,  1,  1,  0};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,   0,  1,  0, 32'h0,     0,  0,  0,  1,  0};
    vecs[7]  = '{0, 0, 0, 1, 32'h40,  0,  1,  1, 32'h40,    0,  1,  1,  1,  1};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,   0,  1,  1, 32'h40,    0,  1,  1,  1,  1};
    vecs[9]  = '{0, 0, 0, 0, 32'h0,   1,  1,  0, 32'h40,    0,  1,  0,  1,  1};
    vecs[10] = '{0, 0, 1, 0, 32'h0,   0,  1,  0, 32'h40,    0,  1,  0,  1,  1};
    vecs[11] = '{0, 0, 0, 0, 32'h0,   0,  1,  0, 32'h40,    0,  0,  0,  1,  1};
    vecs[12] = '{0, 0, 1, 1, 32'h60,  0,  1,  1, 32'h60,    0,  1,  1,  1,  2};
    vecs[13] = '{0, 0, 0, 0, 32'h0,   1,  1,  0, 32'h60,    0,  1,  0,  1,  2};
    vecs[14] = '{0, 0, 0, 1, 32'h80,  0,  1,  1, 32'h80,    0,  1,  1,  1,  3};
    vecs[15] = '{0, 0, 0, 0, 32'h0,   1,  1,  0, 32'h80,    0,  1,  0,  1,  3};
    vecs[16] = '{0, 0, 0, 0, 32'h0,   0,  1,  0, 32'h80,    0,  1,  0,  1,  3};
    vecs[17] = '{0, 0, 0, 0, 32'h0,   0,  1,  0, 32'h80,    0,  0,  0,  1,  3};
    vecs[18] = '{0, 1, 0, 0, 32'h0,   0,  0,  0, 32'h80,    0,  0,  0,  0,  3};
    vecs[19] = '{0, 0, 0, 1, 32'h99,  0,  0,  0, 32'h80,    0,  0,  0,  0,  3};
    vecs[20] = '{0, 0, 1, 0, 32'h0,   0,  0,  0, 32'h80,    0,  0,  0,  0,  3};
    vecs[21] = '{1, 0, 0, 0, 32'h0,   0,  1,  0, 32'h80,    0,  0,  0,  1,  3};
    vecs[22] = '{0, 0, 0, 1, 32'h100, 1,  1,  1, 32'h100,   0,  1,  1,  1,  4};
    vecs[23] = '{0, 0, 0, 0, 32'h0,   1,  1,  0, 32'h100,   0,  1,  0,  1,  4};
    vecs[24] = '{0, 1, 0, 0, 32'h0,   0,  1,  0, 32'h100,   0,  1,  0,  1,  4};
    vecs[25] = '{0, 0, 0, 0, 32'h0,   0,  1,  0, 32'h100,   0,  0,  0,  1,  4};
    vecs[26] = '{0, 1, 0, 0, 32'h0,   0,  0,  0, 32'h100,   0,  0,  0,  0,  4};
    vecs[27] = '{1, 0, 0, 0, 32'h0,   0,  1,  0, 32'h100,   0,  0,  0,  1,  4};
    vecs[28] = '{0, 0, 0, 1, 32'h200, 0,  1,  1, 32'h200,   0,  1,  1,  1,  5};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0);
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, '0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Directed table: each entry is applied for one edge, outputs checked at the next negedge
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].ha, vecs[i].hz, vecs[i].br, vecs[i].tgt, vecs[i].ak);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].e_fce, vecs[i].e_cpc, vecs[i].e_pc,
                vecs[i].e_stl, vecs[i].e_fif, vecs[i].e_fid, vecs[i].e_bsy, vecs[i].e_cnt);
    end

    // Reset in the middle of REDIRECT takes effect without a clock and drops the target
    drive(0, 0, 0, 0, '0, 0);
    #1 rst_n = 1'b0;
    #1 check_all("rst_redirect", 0, 0, '0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, '0, 0);
    @(negedge clk);
    check_all("restart", 1, 0, '0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, '0, 0);
    #2 rst_n = 1'b0;
    #1 check_all("rst_run", 0, 0, '0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            PW'($urandom), ($urandom_range(0, 2) == 0));
      model_step();
      @(negedge clk);
      check_model($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the fetch stage and the IF/ID and ID/EX pipeline registers. Starts and halts fetch, injects bubbles on load-use hazards, and redirects the PC on taken branches/jumps. Holds the redirect until the fetch stage acknowledges it, then flushes wrong-path instructions. Sits beside the pipeline: consumes hazard/branch requests from decode/execute and drives the fetch enable, change-PC and PC-target inputs plus the stage stall/flush controls.

## Interface
- PC_WIDTH, 32, PC and target width
- FLUSH_CYCLES, 2, cycles IF/ID flush stays asserted after an acknowledged redirect (≥1)
- CNT_WIDTH, 8, width of redirect counter
- c_clk  in  1  clock, rising edge
- c_rst  in  1  reset, asynchronous, active-low
- c_i_start  in  1  begin/resume execution (level, sampled)
- c_i_halt  in  1  stop fetching (sampled only in RUN)
- c_i_hazard  in  1  load-use stall request from decode (level)
- c_i_branch  in  1  redirect request from execute (one-cycle pulse)
- c_i_target  in  PC_WIDTH  redirect target, valid with c_i_branch
- c_i_fetch_ce  in  1  fetch-stage output-valid (fetch acknowledge)
- c_o_fetch_ce  out  1  fetch enable
- c_o_change_pc  out  1  select c_o_pc as next fetch PC
- c_o_pc  out  PC_WIDTH  latched redirect target
- c_o_stall_ifid  out  1  hold IF/ID register
- c_o_flush_ifid  out  1  clear IF/ID register
- c_o_flush_idex  out  1  clear ID/EX register (bubble)
- c_o_busy  out  1  state is not IDLE or HALT
- c_o_redirects  out  CNT_WIDTH  count of accepted redirects, saturating

## Operation
- States: IDLE=0, RUN=1, STALL=2, REDIRECT=3, FLUSH=4, HALT=5. All outputs registered, decoded from next state.
- Outputs per state (unlisted = 0): RUN fetch_ce=1; STALL stall_ifid=1, flush_idex=1; REDIRECT fetch_ce=1, change_pc=1, flush_ifid=1, flush_idex=1; FLUSH fetch_ce=1, flush_ifid=1; busy=1 in RUN/STALL/REDIRECT/FLUSH.
- IDLE: c_i_start -> RUN; else stay.
- RUN, priority branch > hazard > halt: branch -> REDIRECT (latch target); hazard -> STALL; halt -> HALT.
- STALL: branch -> REDIRECT; hazard low -> RUN; else stay. Fetch disabled; IF/ID held.
- REDIRECT: hold change_pc and c_o_pc until c_i_fetch_ce sampled 1, then FLUSH, loading flush counter with FLUSH_CYCLES-1. With FLUSH_CYCLES=1, flush counter is 0 on entry, so FLUSH lasts one cycle.
- FLUSH: counter decrements each cycle; at 0 -> RUN. Hazard ignored (instructions being flushed).
- A new c_i_branch in REDIRECT or FLUSH relatches the target, goes to/stays in REDIRECT (handshake restarts), counts as a new redirect.
- HALT: c_i_start -> RUN (resume, no redirect); branch/hazard ignored.
- Halt arriving outside RUN is not remembered; requester holds it until RUN.
- c_o_pc updates only on an accepted branch. Keeps its value otherwise, including across IDLE/HALT.
- c_o_redirects increments once per accepted c_i_branch and saturates at all-ones.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0, c_o_pc=0, counters 0. Reset mid-REDIRECT discards the pending target.
- Request sampled at edge N -> outputs reflect new state in the cycle after edge N (1-cycle latency).
- Redirect handshake: change_pc high from the cycle after branch is sampled until the edge where c_i_fetch_ce=1 is sampled. Minimum REDIRECT duration is 1 cycle.
- FLUSH duration exactly FLUSH_CYCLES cycles. Flush_ifid is continuous from REDIRECT entry through the last FLUSH cycle.
- Branch and hazard in the same RUN/STALL cycle: branch wins. Hazard re-evaluated after return to RUN.
- Branch with c_i_fetch_ce already high on entry: REDIRECT still lasts ≥1 cycle.

## Test plan
- Reset, start=1 for one cycle -> fetch_ce=1 and busy=1 in the cycle after that edge; all other outputs 0; assert reset mid-RUN -> all outputs 0 without waiting for a clock.
- In RUN, hazard high 3 cycles -> stall_ifid=1, flush_idex=1, fetch_ce=0 for exactly 3 cycles, then RUN.
- In RUN, branch with target 0x0000_0040, fetch_ce ack 2 cycles later -> change_pc=1 and pc=0x40 for 2 cycles, then FLUSH 2 cycles (flush_ifid=1), then RUN; c_o_redirects=1.
- Branch and hazard together in RUN -> REDIRECT taken; second branch (target 0x80) during FLUSH -> back to REDIRECT, pc=0x80, c_o_redirects=2.
- Halt in RUN -> HALT, fetch_ce=0, busy=0; branch in HALT ignored (pc unchanged, counter unchanged); start -> RUN.
- CNT_WIDTH=2, 5 redirects -> c_o_redirects saturates at 3.
